// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_fill
// Description : Filled-rectangle draw engine; writes one colour to every pixel
//               of a rectangle over an Avalon-MM write master.
//               Optional clipping build: define VGA_RECT_FILL_CLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_fill #(
    parameter int AVN_AW    = 19,
    parameter int AVN_DW    = 16,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int CW        = 10
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CW-1:0]       cmd_x0,
    input  logic [CW-1:0]       cmd_y0,
    input  logic [CW-1:0]       cmd_x1,
    input  logic [CW-1:0]       cmd_y1,
    input  logic [AVN_DW-1:0]   cmd_color,
    input  logic                cmd_abort,
    output logic                busy,
    output logic                done,
    output logic                cmd_err,
    output logic                framebuffer_avn_write,
    output logic                framebuffer_avn_read,
    output logic [AVN_AW-1:0]   framebuffer_avn_address,
    output logic [AVN_DW-1:0]   framebuffer_avn_writedata,
    output logic [AVN_DW/8-1:0] framebuffer_avn_byteenable,
    input  logic                framebuffer_avn_waitrequest
);

    localparam logic [CW-1:0]     C_XMAX = CW'(H_DISPLAY - 1);
    localparam logic [CW-1:0]     C_YMAX = CW'(V_DISPLAY - 1);
    localparam logic [AVN_AW-1:0] C_HD   = AVN_AW'(H_DISPLAY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]       x_q, x_d, y_q, y_d;
    logic [AVN_AW-1:0]   row_q, row_d;
    logic [AVN_DW-1:0]   color_q, color_d;
    logic                err_q, err_d;
    logic                abort_q, abort_d;

    logic                w_order_err, w_range_err;
    logic [CW-1:0]       w_x0c, w_y0c, w_x1c, w_y1c;

    assign w_order_err = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1);

`ifdef VGA_RECT_FILL_CLIP_EN
    assign w_range_err = 1'b0;
    assign w_x0c = (x0_q > C_XMAX) ? C_XMAX : x0_q;
    assign w_x1c = (x1_q > C_XMAX) ? C_XMAX : x1_q;
    assign w_y0c = (y0_q > C_YMAX) ? C_YMAX : y0_q;
    assign w_y1c = (y1_q > C_YMAX) ? C_YMAX : y1_q;
`else
    assign w_range_err = (cmd_x0 > C_XMAX) || (cmd_x1 > C_XMAX) ||
                         (cmd_y0 > C_YMAX) || (cmd_y1 > C_YMAX);
    assign w_x0c = x0_q;
    assign w_x1c = x1_q;
    assign w_y0c = y0_q;
    assign w_y1c = y1_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            color_q <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            color_q <= color_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        color_d = color_q;
        err_d   = 1'b0;
        abort_d = abort_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    x1_d    = cmd_x1;
                    y1_d    = cmd_y1;
                    color_d = cmd_color;
                    if (w_order_err || w_range_err) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                // The only multiply; the WRITE loop advances rows by addition.
                x0_d    = w_x0c;
                x1_d    = w_x1c;
                y0_d    = w_y0c;
                y1_d    = w_y1c;
                x_d     = w_x0c;
                y_d     = w_y0c;
                row_d   = AVN_AW'(w_y0c) * C_HD;
                abort_d = 1'b0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!framebuffer_avn_waitrequest) begin
                    if (abort_q || cmd_abort || (x_q == x1_q && y_q == y1_q)) begin
                        state_d = S_DONE;
                    end else if (x_q != x1_q) begin
                        x_d = x_q + CW'(1);
                    end else begin
                        x_d   = x0_q;
                        y_d   = y_q + CW'(1);
                        row_d = row_q + C_HD;
                    end
                end else if (cmd_abort) begin
                    // Stalled write must still complete before stopping.
                    abort_d = 1'b1;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready                  = (state_q == S_IDLE);
    assign busy                       = (state_q != S_IDLE);
    assign done                       = (state_q == S_DONE);
    assign cmd_err                    = err_q;
    assign framebuffer_avn_write      = (state_q == S_WRITE);
    assign framebuffer_avn_read       = 1'b0;
    assign framebuffer_avn_address    = row_q + AVN_AW'(x_q);
    assign framebuffer_avn_writedata  = color_q;
    assign framebuffer_avn_byteenable = '1;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_rect_fill
// Description : Self-checking bench for vga_rect_fill with an address scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_fill;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [15:0] cmd_color = '0;
    logic        cmd_abort = 1'b0;
    logic        busy, done, cmd_err;
    logic        avn_write, avn_read;
    logic [18:0] avn_address;
    logic [15:0] avn_writedata;
    logic [1:0]  avn_byteenable;
    logic        avn_waitrequest = 1'b0;

    vga_rect_fill dut (
        .sys_clk                     (sys_clk),
        .sys_rst                     (sys_rst),
        .cmd_valid                   (cmd_valid),
        .cmd_ready                   (cmd_ready),
        .cmd_x0                      (cmd_x0),
        .cmd_y0                      (cmd_y0),
        .cmd_x1                      (cmd_x1),
        .cmd_y1                      (cmd_y1),
        .cmd_color                   (cmd_color),
        .cmd_abort                   (cmd_abort),
        .busy                        (busy),
        .done                        (done),
        .cmd_err                     (cmd_err),
        .framebuffer_avn_write       (avn_write),
        .framebuffer_avn_read        (avn_read),
        .framebuffer_avn_address     (avn_address),
        .framebuffer_avn_writedata   (avn_writedata),
        .framebuffer_avn_byteenable  (avn_byteenable),
        .framebuffer_avn_waitrequest (avn_waitrequest)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          x0, y0, x1, y1;
        logic [15:0] color;
        bit          rnd;
        int          exp_wr;
        bit          exp_err;
    } vec_t;

    vec_t        vt[8];
    int          exp_q[$];
    int          checks = 0, errors = 0;
    int          writes_cnt, done_cnt, err_cnt, cyc = 0, first_cyc, last_cyc, last_addr;
    bit          busy_seen;
    logic [15:0] cur_color;
    int          wr_mode = 0;   // 0: never stall, 1: random stalls, 2: test-controlled

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clr_counters();
        writes_cnt = 0; done_cnt = 0; err_cnt = 0;
        first_cyc = -1; last_cyc = -1; last_addr = -1; busy_seen = 0;
    endtask

    // Reference model: enqueue every address the command should write.
    function automatic int model_push(input int x0, y0, x1, y1);
        int n = 0;
        if (x0 > x1 || y0 > y1) return 0;
`ifdef VGA_RECT_FILL_CLIP_EN
        if (x0 > 639) x0 = 639;
        if (x1 > 639) x1 = 639;
        if (y0 > 479) y0 = 479;
        if (y1 > 479) y1 = 479;
`else
        if (x1 > 639 || y1 > 479) return 0;
`endif
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                exp_q.push_back((y * 640 + x) % (1 << 19));
                n++;
            end
        return n;
    endfunction

    // Stall driver
    initial forever begin
        @(posedge sys_clk); #1;
        if (wr_mode == 0)      avn_waitrequest = 1'b0;
        else if (wr_mode == 1) avn_waitrequest = 1'($urandom_range(0, 1));
    end

    // Monitor: scoreboard compare, stall stability, pulse counting
    initial begin : mon
        bit          prev_stall = 0;
        logic [18:0] prev_addr = '0;
        logic [15:0] prev_data = '0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (sys_rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_write_held", avn_write, 1'b1);
                    check("stall_addr_held", avn_address, prev_addr);
                    check("stall_data_held", avn_writedata, prev_data);
                end
                if (busy) busy_seen = 1;
                if (done) done_cnt++;
                if (cmd_err) err_cnt++;
                if (avn_write && !avn_waitrequest) begin
                    writes_cnt++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc  = cyc;
                    last_addr = int'(avn_address);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_write actual_addr=%0d required=none", avn_address);
                    end else begin
                        check("wr_addr", avn_address, exp_q.pop_front());
                        check("wr_data", avn_writedata, cur_color);
                    end
                end
                prev_stall = avn_write && avn_waitrequest;
                prev_addr  = avn_address;
                prev_data  = avn_writedata;
            end
        end
    end

    task automatic send_cmd(input int x0, y0, x1, y1, input logic [15:0] col);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = col; cur_color = col;
        cmd_valid = 1'b1;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int limit);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < limit) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check("end_timeout", (n >= limit), 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        vt[0] = '{2, 1, 4, 2, 16'hF00F, 0, 6, 0};
        vt[1] = '{2, 1, 4, 2, 16'hF00F, 1, 6, 0};
        vt[2] = '{5, 0, 3, 0, 16'h1111, 0, 0, 1};
`ifdef VGA_RECT_FILL_CLIP_EN
        vt[3] = '{630, 470, 700, 500, 16'hABCD, 0, 100, 0};
`else
        vt[3] = '{630, 470, 700, 500, 16'hABCD, 0, 0, 1};
`endif
        vt[4] = '{0, 0, 0, 0, 16'h1234, 0, 1, 0};
        vt[5] = '{637, 478, 639, 479, 16'h5A5A, 1, 6, 0};
        vt[6] = '{3, 2, 3, 5, 16'h00FF, 1, 4, 0};
        vt[7] = '{1, 4, 1, 3, 16'h7777, 0, 0, 1};

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        check("rst_write", avn_write, 1'b0);
        check("rst_read", avn_read, 1'b0);
        check("rst_address", avn_address, 19'd0);
        check("rst_writedata", avn_writedata, 16'd0);
        check("rst_byteenable", avn_byteenable, 2'b11);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        for (int i = 0; i < 8; i++) begin
            int n;
            clr_counters();
            wr_mode = vt[i].rnd ? 1 : 0;
            n = model_push(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1);
            check($sformatf("v%0d_model_count", i), n, vt[i].exp_wr);
            send_cmd(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].color);
            wait_end(1000);
            check($sformatf("v%0d_writes", i), writes_cnt, vt[i].exp_wr);
            check($sformatf("v%0d_err_pulses", i), err_cnt, vt[i].exp_err);
            check($sformatf("v%0d_done_pulses", i), done_cnt, vt[i].exp_err ? 0 : 1);
            check($sformatf("v%0d_sb_left", i), exp_q.size(), 0);
            check($sformatf("v%0d_ready_after", i), cmd_ready, 1'b1);
            if (vt[i].exp_err)
                check($sformatf("v%0d_busy_seen", i), busy_seen, 1'b0);
            if (!vt[i].rnd && vt[i].exp_wr > 0)
                check($sformatf("v%0d_burst_len", i), last_cyc - first_cyc + 1, vt[i].exp_wr);
`ifdef VGA_RECT_FILL_CLIP_EN
            if (i == 3) check("clip_last_addr", last_addr, 307199);
`endif
            exp_q.delete();
        end

        // Full-screen fill aborted during a stall after 1000 accepts
        begin
            int n = 0;
            clr_counters();
            wr_mode = 0;
            for (int a = 0; a <= 1000; a++) exp_q.push_back(a);
            send_cmd(0, 0, 639, 479, 16'hC0DE);
            while (writes_cnt < 1000 && n < 3000) begin
                @(posedge sys_clk); #1;
                n++;
            end
            check("abort_reach_1000", writes_cnt, 1000);
            wr_mode = 2;
            avn_waitrequest = 1'b1;
            cmd_abort = 1'b1;
            repeat (2) @(posedge sys_clk);
            #1;
            cmd_abort = 1'b0;
            repeat (2) @(posedge sys_clk);
            #1;
            check("abort_held_writes", writes_cnt, 1000);
            avn_waitrequest = 1'b0;
            wait_end(100);
            check("abort_total_writes", writes_cnt, 1001);
            check("abort_done_pulses", done_cnt, 1);
            check("abort_sb_left", exp_q.size(), 0);
            exp_q.delete();
            wr_mode = 0;
        end

        // Reset mid-fill, then a single-pixel command
        begin
            int n = 0;
            clr_counters();
            void'(model_push(0, 0, 9, 9));
            send_cmd(0, 0, 9, 9, 16'h3C3C);
            while (writes_cnt < 5 && n < 200) begin
                @(posedge sys_clk); #1;
                n++;
            end
            check("midrst_reach_5", writes_cnt, 5);
            wr_mode = 2;
            avn_waitrequest = 1'b1;
            sys_rst = 1'b1;
            @(posedge sys_clk); #1;
            check("midrst_write", avn_write, 1'b0);
            check("midrst_busy", busy, 1'b0);
            check("midrst_ready", cmd_ready, 1'b1);
            check("midrst_writedata", avn_writedata, 16'd0);
            sys_rst = 1'b0;
            avn_waitrequest = 1'b0;
            wr_mode = 0;
            exp_q.delete();
            @(posedge sys_clk); #1;
            clr_counters();
            void'(model_push(0, 0, 0, 0));
            send_cmd(0, 0, 0, 0, 16'h0F0F);
            wait_end(100);
            check("postrst_writes", writes_cnt, 1);
            check("postrst_last_addr", last_addr, 0);
            check("postrst_done", done_cnt, 1);
            check("postrst_sb_left", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
